// File: rtl/jedro_1_lsu.sv
// Load-store unit for jedro_1: one memory operation at a time over a req/gnt/rvalid bus,
// with byte-lane steering for stores and sign/zero extension for load writeback.
module jedro_1_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_valid_i,
  output logic                      ctrl_ready_o,
  input  logic                      ctrl_we_i,
  input  logic [1:0]                ctrl_size_i,
  input  logic                      ctrl_unsigned_i,
  input  logic [DATA_WIDTH-1:0]     ctrl_addr_i,
  input  logic [DATA_WIDTH-1:0]     ctrl_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] ctrl_rd_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_data_o,
  output logic                      misaligned_o,
  output logic                      bus_err_o,
  output logic [DATA_WIDTH-1:0]     err_addr_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [DATA_WIDTH-1:0]     data_addr_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_e                    state_q;
  logic                      rf_we_q;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_q;
  logic [DATA_WIDTH-1:0]     rf_data_q;
  logic                      misaligned_q;
  logic                      bus_err_q;
  logic [DATA_WIDTH-1:0]     err_addr_q;
  logic                      data_req_q;
  logic                      data_we_q;
  logic [3:0]                data_be_q;
  logic [DATA_WIDTH-1:0]     data_addr_q;
  logic [DATA_WIDTH-1:0]     data_wdata_q;

  // Per-operation context kept for the response phase.
  logic [1:0]                addr_lo_q;
  logic [1:0]                size_q;
  logic                      unsigned_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     addr_full_q;

  logic                      accept;
  logic                      misaligned_d;
  logic [3:0]                be_d;
  logic [DATA_WIDTH-1:0]     wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_shifted;
  logic [DATA_WIDTH-1:0]     rf_data_d;

  assign ctrl_ready_o = (state_q == IDLE);
  assign accept       = ctrl_valid_i & ctrl_ready_o;

  always_comb begin
    misaligned_d = 1'b0;
    case (ctrl_size_i)
      SIZE_BYTE: misaligned_d = 1'b0;
      SIZE_HALF: misaligned_d = ctrl_addr_i[0];
      SIZE_WORD: misaligned_d = |ctrl_addr_i[1:0];
      default:   misaligned_d = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ctrl_wdata_i;
    case (ctrl_size_i)
      SIZE_BYTE: begin
        be_d    = 4'b0001 << ctrl_addr_i[1:0];
        wdata_d = {4{ctrl_wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        be_d    = 4'b0011 << {ctrl_addr_i[1], 1'b0};
        wdata_d = {2{ctrl_wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = ctrl_wdata_i;
      end
    endcase
  end

  assign rdata_shifted = data_rdata_i >> {addr_lo_q, 3'b000};

  always_comb begin
    rf_data_d = rdata_shifted;
    case (size_q)
      SIZE_BYTE: rf_data_d = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, rdata_shifted[7:0]}
                                        : {{(DATA_WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      SIZE_HALF: rf_data_d = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, rdata_shifted[15:0]}
                                        : {{(DATA_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      default:   rf_data_d = rdata_shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      err_addr_q   <= '0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= 4'b0000;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      addr_lo_q    <= 2'b00;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      rd_q         <= '0;
      addr_full_q  <= '0;
    end else begin
      rf_we_q      <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (misaligned_d) begin
              // Faults never reach the bus; staying in IDLE permits back-to-back accepts.
              misaligned_q <= 1'b1;
              err_addr_q   <= ctrl_addr_i;
            end else begin
              state_q      <= REQ;
              data_req_q   <= 1'b1;
              data_we_q    <= ctrl_we_i;
              data_be_q    <= be_d;
              data_addr_q  <= {ctrl_addr_i[DATA_WIDTH-1:2], 2'b00};
              data_wdata_q <= wdata_d;
              addr_lo_q    <= ctrl_addr_i[1:0];
              size_q       <= ctrl_size_i;
              unsigned_q   <= ctrl_unsigned_i;
              rd_q         <= ctrl_rd_i;
              addr_full_q  <= ctrl_addr_i;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            state_q    <= WAIT;
            data_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (data_rvalid_i) begin
            state_q <= IDLE;
            if (data_err_i) begin
              bus_err_q  <= 1'b1;
              err_addr_q <= addr_full_q;
            end else if (!data_we_q && (rd_q != '0)) begin
              rf_we_q   <= 1'b1;
              rf_addr_q <= rd_q;
              rf_data_q <= rf_data_d;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          data_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_addr_o    = rf_addr_q;
  assign rf_data_o    = rf_data_q;
  assign misaligned_o = misaligned_q;
  assign bus_err_o    = bus_err_q;
  assign err_addr_o   = err_addr_q;
  assign data_req_o   = data_req_q;
  assign data_we_o    = data_we_q;
  assign data_be_o    = data_be_q;
  assign data_addr_o  = data_addr_q;
  assign data_wdata_o = data_wdata_q;

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Directed bench for jedro_1_lsu: bus handshake, lane steering, load extension,
// misalignment, bus errors and reset abort, with a writeback scoreboard.
module tb_jedro_1_lsu;

  localparam int SB_W = 37;  // {rd[4:0], data[31:0]}

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        ctrl_valid_i = 1'b0;
  logic        ctrl_ready_o;
  logic        ctrl_we_i = 1'b0;
  logic [1:0]  ctrl_size_i = 2'b00;
  logic        ctrl_unsigned_i = 1'b0;
  logic [31:0] ctrl_addr_i = '0;
  logic [31:0] ctrl_wdata_i = '0;
  logic [4:0]  ctrl_rd_i = '0;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic [31:0] err_addr_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i = '0;
  logic        data_err_i = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [SB_W-1:0] exp_q[$];

  jedro_1_lsu dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ctrl_valid_i(ctrl_valid_i), .ctrl_ready_o(ctrl_ready_o), .ctrl_we_i(ctrl_we_i),
    .ctrl_size_i(ctrl_size_i), .ctrl_unsigned_i(ctrl_unsigned_i), .ctrl_addr_i(ctrl_addr_i),
    .ctrl_wdata_i(ctrl_wdata_i), .ctrl_rd_i(ctrl_rd_i),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o), .err_addr_o(err_addr_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver for one aligned operation. Entered and left at a negedge; inputs are
  // driven and outputs sampled at negedges, away from the active edge.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int gnt_delay, input logic [31:0] rdata, input logic err,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rf);
    logic exp_we;
    logic [SB_W-1:0] ent;
    exp_we = !we && (rd != 5'd0) && !err;
    chk("ready_c0", {31'b0, ctrl_ready_o}, 32'd1);
    ctrl_valid_i = 1'b1; ctrl_we_i = we; ctrl_size_i = size; ctrl_unsigned_i = uns;
    ctrl_addr_i = addr; ctrl_wdata_i = wdata; ctrl_rd_i = rd;
    if (exp_we) exp_q.push_back({rd, exp_rf});
    @(negedge clk_i);
    ctrl_valid_i = 1'b0;
    chk("misaligned_quiet", {31'b0, misaligned_o}, 32'd0);
    for (int i = 0; i <= gnt_delay; i++) begin
      chk("req_high", {31'b0, data_req_o}, 32'd1);
      chk("ready_low_req", {31'b0, ctrl_ready_o}, 32'd0);
      chk("bus_addr", data_addr_o, {addr[31:2], 2'b00});
      chk("bus_we", {31'b0, data_we_o}, {31'b0, we});
      chk("bus_be", {28'b0, data_be_o}, {28'b0, exp_be});
      if (we) chk("bus_wdata", data_wdata_o, exp_wdata);
      if (we) chk("no_rf_we_store", {31'b0, rf_we_o}, 32'd0);
      if (i == gnt_delay) data_gnt_i = 1'b1;
      @(negedge clk_i);
    end
    data_gnt_i = 1'b0;
    chk("req_dropped", {31'b0, data_req_o}, 32'd0);
    chk("ready_low_wait", {31'b0, ctrl_ready_o}, 32'd0);
    data_rvalid_i = 1'b1; data_rdata_i = rdata; data_err_i = err;
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
    chk("ready_c3", {31'b0, ctrl_ready_o}, 32'd1);
    chk("rf_we_c3", {31'b0, rf_we_o}, {31'b0, exp_we});
    chk("bus_err_c3", {31'b0, bus_err_o}, {31'b0, err});
    if (err) chk("err_addr", err_addr_o, addr);
    if (rf_we_o) begin
      chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        chk("rf_addr", {27'b0, rf_addr_o}, {27'b0, ent[36:32]});
        chk("rf_data", rf_data_o, ent[31:0]);
      end
    end
    @(negedge clk_i);
    chk("rf_we_pulse_end", {31'b0, rf_we_o}, 32'd0);
    chk("bus_err_pulse_end", {31'b0, bus_err_o}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", {31'b0, ctrl_ready_o}, 32'd1);
    chk("rst_req", {31'b0, data_req_o}, 32'd0);
    chk("rst_rf_we", {31'b0, rf_we_o}, 32'd0);
    chk("rst_be", {28'b0, data_be_o}, 32'd0);
    chk("rst_err_addr", err_addr_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Aligned word load
    run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 1'b0,
           4'b1111, 32'h0, 32'hDEADBEEF);
    // Byte / half loads from 0x80FF7F01
    run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd6, 0, 32'h80FF7F01, 1'b0,
           4'b1000, 32'h0, 32'hFFFFFF80);
    run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd7, 0, 32'h80FF7F01, 1'b0,
           4'b1000, 32'h0, 32'h00000080);
    run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd8, 0, 32'h80FF7F01, 1'b0,
           4'b1100, 32'h0, 32'hFFFF80FF);
    run_op(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 5'd9, 1, 32'h12348001, 1'b0,
           4'b0011, 32'h0, 32'h00008001);
    run_op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 5'd10, 0, 32'h80FF7F01, 1'b0,
           4'b0010, 32'h0, 32'h0000007F);
    // Half store with grant withheld three cycles
    run_op(1'b1, 2'b01, 1'b0, 32'h206, 32'h1234ABCD, 5'd3, 3, 32'h0, 1'b0,
           4'b1100, 32'hABCDABCD, 32'h0);
    // Byte and word stores
    run_op(1'b1, 2'b00, 1'b0, 32'h001, 32'h000000AB, 5'd0, 0, 32'h0, 1'b0,
           4'b0010, 32'hABABABAB, 32'h0);
    run_op(1'b1, 2'b10, 1'b0, 32'h010, 32'hCAFEF00D, 5'd0, 2, 32'h0, 1'b0,
           4'b1111, 32'hCAFEF00D, 32'h0);

    // Misaligned word load, then an aligned op accepted right after
    ctrl_valid_i = 1'b1; ctrl_we_i = 1'b0; ctrl_size_i = 2'b10; ctrl_addr_i = 32'h101;
    ctrl_rd_i = 5'd4;
    @(negedge clk_i);
    ctrl_valid_i = 1'b0;
    chk("mis_pulse", {31'b0, misaligned_o}, 32'd1);
    chk("mis_err_addr", err_addr_o, 32'h101);
    chk("mis_no_req", {31'b0, data_req_o}, 32'd0);
    chk("mis_ready", {31'b0, ctrl_ready_o}, 32'd1);
    run_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5'd11, 0, 32'h01020304, 1'b0,
           4'b1111, 32'h0, 32'h01020304);

    // Illegal size and misaligned half
    ctrl_valid_i = 1'b1; ctrl_size_i = 2'b11; ctrl_addr_i = 32'h200;
    @(negedge clk_i);
    chk("illegal_pulse", {31'b0, misaligned_o}, 32'd1);
    chk("illegal_err_addr", err_addr_o, 32'h200);
    ctrl_size_i = 2'b01; ctrl_addr_i = 32'h333;
    @(negedge clk_i);
    ctrl_valid_i = 1'b0;
    chk("half_mis_pulse", {31'b0, misaligned_o}, 32'd1);
    chk("half_mis_err_addr", err_addr_o, 32'h333);
    chk("half_mis_no_req", {31'b0, data_req_o}, 32'd0);
    @(negedge clk_i);
    chk("mis_pulse_end", {31'b0, misaligned_o}, 32'd0);

    // Bus error and load to x0
    run_op(1'b0, 2'b10, 1'b0, 32'h30C, 32'h0, 5'd12, 1, 32'hFFFFFFFF, 1'b1,
           4'b1111, 32'h0, 32'h0);
    run_op(1'b0, 2'b00, 1'b0, 32'h402, 32'h0, 5'd0, 0, 32'h00AA0000, 1'b0,
           4'b0100, 32'h0, 32'h0);
    chk("rf_addr_held", {27'b0, rf_addr_o}, 32'd11);
    chk("rf_data_held", rf_data_o, 32'h01020304);

    // Reset during WAIT, then a stale rvalid
    ctrl_valid_i = 1'b1; ctrl_we_i = 1'b0; ctrl_size_i = 2'b10; ctrl_addr_i = 32'h400;
    ctrl_rd_i = 5'd7;
    @(negedge clk_i);
    ctrl_valid_i = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    chk("rst_wait_state", {31'b0, ctrl_ready_o}, 32'd0);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, data_req_o}, 32'd0);
    chk("rst_mid_ready", {31'b0, ctrl_ready_o}, 32'd1);
    @(negedge clk_i);
    rstn_i = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h55555555;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("rst_stale_rf_we", {31'b0, rf_we_o}, 32'd0);
    chk("rst_stale_bus_err", {31'b0, bus_err_o}, 32'd0);
    chk("rst_after_ready", {31'b0, ctrl_ready_o}, 32'd1);
    chk("rst_after_req", {31'b0, data_req_o}, 32'd0);
    @(negedge clk_i);
    chk("rst_late_rf_we", {31'b0, rf_we_o}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jedro_1_lsu.md
Name: jedro_1_lsu

Overview:
Load-store controller for the jedro_1 core. It accepts one memory operation at a time from the decode/control stage and sequences the data interface (req/gnt/rvalid handshake). It produces byte enables and replicated store data, and sign- or zero-extends load data for register-file writeback. It reports misaligned accesses and bus errors to the core control FSM.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.
REG_ADDR_WIDTH, 5, register-file destination address width.

Ports:
clk_i  input  1  core clock
rstn_i  input  1  reset
ctrl_valid_i  input  1  memory operation presented
ctrl_ready_o  output  1  LSU can accept an operation
ctrl_we_i  input  1  1 = store, 0 = load
ctrl_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
ctrl_unsigned_i  input  1  zero-extend load (LBU/LHU)
ctrl_addr_i  input  DATA_WIDTH  effective byte address
ctrl_wdata_i  input  DATA_WIDTH  store data (rs2)
ctrl_rd_i  input  REG_ADDR_WIDTH  load destination register
rf_we_o  output  1  writeback strobe
rf_addr_o  output  REG_ADDR_WIDTH  writeback register
rf_data_o  output  DATA_WIDTH  extended load data
misaligned_o  output  1  misaligned/illegal-size pulse
bus_err_o  output  1  bus error pulse
err_addr_o  output  DATA_WIDTH  faulting byte address
data_req_o  output  1  bus request
data_gnt_i  input  1  bus grant
data_rvalid_i  input  1  response valid
data_we_o  output  1  bus write enable
data_be_o  output  4  byte enables
data_addr_o  output  DATA_WIDTH  word-aligned bus address
data_wdata_o  output  DATA_WIDTH  bus write data
data_rdata_i  input  DATA_WIDTH  bus read data
data_err_i  input  1  bus error, qualified by data_rvalid_i

Behaviour:
- One clock, clk_i, rising edge. Reset rstn_i is asynchronous and active-low.
- While in reset, all registered outputs are 0 and the state is IDLE. Consequently ctrl_ready_o = 1.
- Reset mid-operation aborts the transaction. Any rvalid arriving after reset is ignored.
- ctrl_ready_o = (state == IDLE), combinational. An operation is accepted on ctrl_valid_i & ctrl_ready_o.
- Misaligned condition on acceptance:
  - size 11, or
  - half with addr[0] = 1, or
  - word with addr[1:0] != 0.
- Misaligned handling:
  - Next cycle: misaligned_o = 1 for exactly one cycle, and err_addr_o = ctrl_addr_i.
  - No bus request is issued and state stays IDLE, so back-to-back acceptance is allowed.
- Aligned acceptance registers the following and moves to REQ:
  - data_addr_o = {addr[31:2], 2'b00}, data_we_o = ctrl_we_i.
  - Byte: data_be_o = 4'b0001 << addr[1:0], data_wdata_o = {4{wdata[7:0]}}.
  - Half: data_be_o = 4'b0011 << {addr[1], 1'b0}, data_wdata_o = {2{wdata[15:0]}}.
  - Word: data_be_o = 4'b1111, data_wdata_o = wdata.
  - Also latched internally: addr[1:0], size, unsigned, rd, and the full address.
- REQ state:
  - data_req_o = 1, with addr/we/be/wdata held stable until the grant.
  - On data_gnt_i, data_req_o drops the next cycle and state moves to WAIT.
  - data_rvalid_i is ignored in REQ and IDLE.
- WAIT state: data_req_o = 0. On data_rvalid_i, return to IDLE, and in the following cycle:
  - If data_err_i: bus_err_o = 1 for one cycle, err_addr_o = latched full address, no writeback.
  - Else if load with rd != 0: rf_we_o = 1 for one cycle, rf_addr_o = rd, and rf_data_o is extracted from data_rdata_i >> (8*addr[1:0]).
    - Byte: bits [7:0], sign- or zero-extended per ctrl_unsigned_i.
    - Half: bits [15:0], sign- or zero-extended per ctrl_unsigned_i.
    - Word: unchanged.
  - Else (store, or load to x0): no pulse.
- rf_addr_o, rf_data_o and err_addr_o hold their last value between pulses.
- Minimum latency:
  - Load: accept c0, req c1 (gnt c1), rvalid c2, rf_we_o and ready both high in c3.
  - Store completes with ready high in c3.
- Grant stall: data_req_o stays high indefinitely with stable payload; ctrl_ready_o stays 0.
- Only one outstanding transaction exists at any time.

Test Plan:
- Reset mid-transaction: assert reset during WAIT, then deliver rvalid -> no rf_we_o, no bus_err_o; data_req_o = 0 and ctrl_ready_o = 1 after reset.
- Aligned word load:
  - Stimulus: addr 0x100, rd = 5, gnt in c1, rvalid in c2, rdata 0xDEADBEEF.
  - Response: data_addr_o = 0x100, be = 1111 in c1; c3 rf_we_o = 1, rf_addr_o = 5, rf_data_o = 0xDEADBEEF.
- Byte load, rdata 0x80FF7F01:
  - Signed, addr 0x103 -> rf_data_o = 0xFFFFFF80, be = 1000.
  - LBU, addr 0x103 -> 0x00000080.
  - LH, addr 0x102 -> 0xFFFF80FF.
- Half store with stall:
  - Stimulus: addr 0x206, wdata 0x1234ABCD, gnt withheld 3 cycles.
  - Response: data_req_o high 4 cycles, be = 1100, data_wdata_o = 0xABCDABCD stable throughout; no rf_we_o.
- Misaligned word load at 0x101 -> misaligned_o pulse 1 cycle, err_addr_o = 0x101, no data_req_o. The next op is accepted the following cycle.
- Bus error: load with rvalid & data_err_i -> bus_err_o 1 cycle, err_addr_o = request address, rf_we_o stays 0. A load to rd = 0 never asserts rf_we_o.
